// File: rtl/fp_pkg.sv
// Shared single-precision types and constants for the FPU slice.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam logic [7:0]  EXP_MAX    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    DONE
  } fsub_state_t;

endpackage

// File: rtl/fp_classify.sv
// Operand classifier: zero (denormals flushed), infinity, NaN.
module fp_classify
  import fp_pkg::*;
(
  input  logic [7:0]  exp,
  input  logic [22:0] frac,
  output fp_class_t   cls
);

  always_comb begin
    cls.zero = (exp == 8'd0);
    cls.inf  = (exp == EXP_MAX) && (frac == 23'd0);
    cls.nan  = (exp == EXP_MAX) && (frac != 23'd0);
  end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision subtractor, result = data1 - data2.
// Bit-serial alignment and normalisation, truncating arithmetic.
module fp_subtractor_seq
  import fp_pkg::*;
#(
  parameter int MAX_ALIGN = 25
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam int CW = $clog2(MAX_ALIGN + 1);
  localparam logic [7:0] ALIGN_CAP = 8'(MAX_ALIGN);

  fsub_state_t state, state_n;
  fp32_t a, b;
  fp_class_t c1, c2;

  logic [23:0]       big_m, small_m;
  logic [24:0]       m_r;
  logic signed [9:0] exp_r;
  logic [CW-1:0]     cnt;
  logic s1_r, s2_r, big_is_a, is_add, sign_r;

  logic        special;
  logic [31:0] spec_res;
  logic        a_big;
  logic [7:0]  ediff;
  logic [CW-1:0] d;
  logic [24:0] sub_m;
  logic        sub_sign;
  logic [24:0] norm_m;
  logic signed [9:0] norm_exp;
  logic        norm_end;
  logic [22:0] fin_frac;
  logic signed [9:0] fin_exp;
  logic        fin_sign, fin_ovf, fin_unf;
  logic [31:0] fin_res;

  assign a = data1;
  assign b = data2;

  fp_classify u_cls1 (.exp(a.exp), .frac(a.frac), .cls(c1));
  fp_classify u_cls2 (.exp(b.exp), .frac(b.frac), .cls(c2));

  always_comb begin
    special = c1.zero | c1.inf | c1.nan | c2.zero | c2.inf | c2.nan;
    spec_res = '0;
    if (c1.nan | c2.nan | (c1.inf & c2.inf & (a.sign == b.sign)))
      spec_res = FP_QNAN;
    else if (c1.inf)
      spec_res = {a.sign, FP_POS_INF[30:0]};
    else if (c2.inf)
      spec_res = {~b.sign, FP_POS_INF[30:0]};
    else if (c1.zero & c2.zero)
      spec_res = {a.sign & ~b.sign, 31'd0};
    else if (c2.zero)
      spec_res = data1;
    else
      spec_res = {~b.sign, data2[30:0]};
  end

  always_comb begin
    a_big = (a.exp >= b.exp);
    ediff = a_big ? (a.exp - b.exp) : (b.exp - a.exp);
    d = (ediff >= ALIGN_CAP) ? ALIGN_CAP[CW-1:0] : ediff[CW-1:0];
  end

  // Subtract sign follows the larger magnitude; data2 counts negated.
  always_comb begin
    sub_m = '0;
    sub_sign = s1_r;
    if (is_add) begin
      sub_m = {1'b0, big_m} + {1'b0, small_m};
    end else if (big_m >= small_m) begin
      sub_m = {1'b0, big_m - small_m};
      sub_sign = big_is_a ? s1_r : ~s2_r;
    end else begin
      sub_m = {1'b0, small_m - big_m};
      sub_sign = big_is_a ? ~s2_r : s1_r;
    end
  end

  always_comb begin
    if (m_r[24]) begin
      norm_m = m_r >> 1;
      norm_exp = exp_r + 10'sd1;
      norm_end = 1'b1;
    end else begin
      norm_m = m_r << 1;
      norm_exp = exp_r - 10'sd1;
      norm_end = m_r[22];
    end
  end

  always_comb begin
    if (state == NORM) begin
      fin_frac = norm_m[22:0];
      fin_exp = norm_exp;
      fin_sign = sign_r;
    end else begin
      fin_frac = sub_m[22:0];
      fin_exp = exp_r;
      fin_sign = sub_sign;
    end
    fin_ovf = (fin_exp >= 10'sd255);
    fin_unf = (fin_exp <= 10'sd0);
    if (fin_ovf)
      fin_res = {fin_sign, EXP_MAX, 23'd0};
    else if (fin_unf)
      fin_res = {fin_sign, 31'd0};
    else
      fin_res = {fin_sign, fin_exp[7:0], fin_frac};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (in_valid)
          state_n = special ? DONE : (d != '0) ? ALIGN : SUB;
      ALIGN:
        if (cnt == CW'(1)) state_n = SUB;
      SUB:
        if (sub_m == 25'd0) state_n = DONE;
        else if (sub_m[24] | ~sub_m[23]) state_n = NORM;
        else state_n = DONE;
      NORM:
        if (norm_end) state_n = DONE;
      DONE:
        if (out_valid & out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      big_m <= '0;
      small_m <= '0;
      m_r <= '0;
      exp_r <= '0;
      cnt <= '0;
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      big_is_a <= 1'b0;
      is_add <= 1'b0;
      sign_r <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (in_valid) begin
            s1_r <= a.sign;
            s2_r <= b.sign;
            is_add <= a.sign ^ b.sign;
            big_is_a <= a_big;
            cnt <= d;
            big_m <= a_big ? {1'b1, a.frac} : {1'b1, b.frac};
            small_m <= a_big ? {1'b1, b.frac} : {1'b1, a.frac};
            exp_r <= {2'b00, a_big ? a.exp : b.exp};
            if (special) begin
              result <= spec_res;
              overflow <= 1'b0;
              underflow <= 1'b0;
            end
          end
        ALIGN: begin
          small_m <= small_m >> 1;
          cnt <= cnt - 1'b1;
        end
        SUB: begin
          m_r <= sub_m;
          sign_r <= sub_sign;
          if (state_n == DONE) begin
            result <= (sub_m == 25'd0) ? 32'd0 : fin_res;
            overflow <= (sub_m != 25'd0) & fin_ovf;
            underflow <= (sub_m != 25'd0) & fin_unf;
          end
        end
        NORM: begin
          m_r <= norm_m;
          exp_r <= norm_exp;
          if (norm_end) begin
            result <= fin_res;
            overflow <= fin_ovf;
            underflow <= fin_unf;
          end
        end
        // out_valid rises one edge after the result register is loaded
        DONE:
          out_valid <= ~(out_valid & out_ready);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Randomised self-checking bench for fp_subtractor_seq.
module tb_fp_subtractor_seq;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid, in_ready;
  logic [31:0] data1, data2;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow;

  int n_assert = 0;
  int n_fail = 0;

  fp_subtractor_seq #(.MAX_ALIGN(25)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: signed-integer mantissa arithmetic at the big exponent.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov,
                                output logic un, output int lat);
    int e1, e2, ea, d, n, ma, mb, diff;
    logic s1, s2, z1, z2, i1, i2, n1, n2, sg;
    s1 = a[31]; s2 = b[31];
    e1 = int'(a[30:23]); e2 = int'(b[30:23]);
    ma = int'({1'b1, a[22:0]}); mb = int'({1'b1, b[22:0]});
    z1 = (e1 == 0); z2 = (e2 == 0);
    i1 = (e1 == 255) && (a[22:0] == 0);
    i2 = (e2 == 255) && (b[22:0] == 0);
    n1 = (e1 == 255) && (a[22:0] != 0);
    n2 = (e2 == 255) && (b[22:0] != 0);
    ov = 1'b0; un = 1'b0; lat = 1; r = '0;
    if (n1 || n2 || (i1 && i2 && s1 == s2)) r = 32'h7FC00000;
    else if (i1) r = {s1, 8'hFF, 23'd0};
    else if (i2) r = {~s2, 8'hFF, 23'd0};
    else if (z1 && z2) r = {s1 & ~s2, 31'd0};
    else if (z2) r = a;
    else if (z1) r = {~s2, b[30:0]};
    else begin
      d = (e1 > e2) ? e1 - e2 : e2 - e1;
      if (d > 25) d = 25;
      ea = (e1 > e2) ? e1 : e2;
      if (e1 >= e2) mb = mb >> d;
      else ma = ma >> d;
      diff = (s1 ? -ma : ma) - (s2 ? -mb : mb);
      sg = (diff < 0);
      if (sg) diff = -diff;
      if (diff == 0) begin
        r = 32'd0;
        lat = 2 + d;
      end else begin
        n = 0;
        if (diff >= (1 << 24)) begin
          diff = diff >> 1; ea++; n = 1;
        end else begin
          while (diff < (1 << 23)) begin
            diff = diff << 1; ea--; n++;
          end
        end
        lat = 2 + d + n;
        if (ea >= 255) begin
          ov = 1'b1; r = {sg, 8'hFF, 23'd0};
        end else if (ea <= 0) begin
          un = 1'b1; r = {sg, 31'd0};
        end else begin
          r = {sg, ea[7:0], diff[22:0]};
        end
      end
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo,
                        input logic eu, input int el, input int hold);
    int k;
    @(negedge CLK);
    data1 = a; data2 = b; in_valid = 1'b1;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge CLK);
      #1 k++;
    end
    check("latency", k, el);
    check("result", result, er);
    check("overflow", {31'd0, overflow}, {31'd0, eo});
    check("underflow", {31'd0, underflow}, {31'd0, eu});
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      data1 = $urandom; data2 = $urandom;
      check("hold_result", result, er);
      check("hold_flags", {30'd0, overflow, underflow}, {30'd0, eo, eu});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_fp(input logic [31:0] ref_v);
    int mode, e;
    logic [31:0] v;
    mode = $urandom_range(0, 9);
    v = $urandom;
    e = int'(ref_v[30:23]) + $urandom_range(0, 4) - 2;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    case (mode)
      4, 5, 6: v[30:23] = e[7:0];
      7: v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      8: v = {v[31], ref_v[30:0]};
      9: v[30:23] = 8'(250 + $urandom_range(0, 4));
      default: ;
    endcase
    if (mode == 7 && $urandom_range(0, 1) != 0) v[22:0] = 23'd0;
    return v;
  endfunction

  initial begin
    logic [31:0] a, b, er;
    logic eo, eu;
    int el;
    nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data1 = '0; data2 = '0;
    repeat (2) @(negedge CLK);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    nRST = 1'b1;

    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 3, 0);
    run_op(32'h3F800000, 32'h40400000, 32'hC0000000, 0, 0, 3, 0);
    run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 0, 0, 3, 0);
    run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0, 2, 0);
    run_op(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 0, 0, 26, 0);
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1, 0, 3, 0);
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 0, 1, 0);
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 3, 10);
    repeat (3) @(posedge CLK);
    #1 check("no_accept_in_done", {31'd0, out_valid}, 32'd0);

    @(negedge CLK);
    data1 = 32'h4B000000; data2 = 32'h3F800000; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 3, 0);

    for (int i = 0; i < 300; i++) begin
      a = rnd_fp($urandom);
      b = rnd_fp(a);
      model(a, b, er, eo, eu, el);
      run_op(a, b, er, eo, eu, el, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_subtractor_seq.md
Name: fp_subtractor_seq

Overview:
Multi-cycle IEEE-754 single-precision subtractor that computes result = data1 - data2. It complements the team's combinational adder and serves the FPU subtract path. Alignment and normalisation are iterative, one bit per cycle, which trades latency for area. Operands and results move through valid/ready handshakes on both sides.

Parameters:
MAX_ALIGN, 25, alignment shift cap; exponent differences at or above this value zero the smaller mantissa.

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair
data1  in  32  minuend (IEEE-754 single)
data2  in  32  subtrahend (IEEE-754 single)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  32  data1 - data2
overflow  out  1  result exponent saturated; result is ±inf
underflow  out  1  result exponent fell to zero or below; result flushed to signed zero

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (nRST).
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, underflow=0. Asserting nRST mid-operation discards the operation; no partial output is produced.
- States: IDLE, ALIGN, SUB, NORM, DONE.
- IDLE: in_ready=1. Acceptance is in_valid&in_ready at a clock edge; operands are registered at that edge.
- Operand classification at acceptance:
  - exp==0 is treated as zero; denormals are flushed.
  - exp==FF: any NaN, or inf-inf with equal signs, gives 0x7FC00000.
  - Otherwise an infinite operand gives inf with sign1 if data1 is inf, else ~sign2.
  - Zero operand: data2 zero gives data1; data1 zero gives data2 with its sign inverted. Both zero gives sign1&~sign2 with exp=0, mant=0.
  - All special and zero cases go straight to DONE with overflow=underflow=0.
- Normal operands:
  - Effective operation is add if sign1!=sign2, else subtract.
  - The larger-exponent operand is the big operand; d = min(|exp1-exp2|, MAX_ALIGN).
  - Next state is ALIGN if d>0, else SUB.
- ALIGN: shift the small 24-bit mantissa (implicit 1 included) right by 1 per cycle, decrementing the counter. When the counter reaches 0, go to SUB. Shifted-out bits are discarded (truncation).
- SUB: one cycle, 25-bit result.
  - Add: m = big + small.
  - Subtract: m = larger magnitude - smaller magnitude. Sign is that of the larger-magnitude operand, where the data2 sign is taken as inverted. Mantissas are compared after alignment.
  - m==0 goes to DONE with result +0, underflow=0.
  - m[24]=1 or m[23]=0 goes to NORM; otherwise DONE.
- NORM, one shift per cycle:
  - If m[24]: shift right by 1, exp+1, then DONE.
  - Else: shift left by 1 and exp-1 while m[23]==0.
- Exponent arithmetic uses a 10-bit signed value.
  - exp>=255 sets overflow=1 and result = sign,0xFF,0.
  - exp<=0 sets underflow=1 and result = sign,0,0.
- DONE: out_valid=1; result and flags are held stable until out_valid&out_ready, then the block returns to IDLE.
  - in_ready=0 in every state except IDLE, so there is no overlap or pipelining.
  - A new operand pair is accepted no earlier than the cycle after the output handshake.
- Latency from acceptance edge to first out_valid edge: 2+d+n edges, where n = number of NORM cycles. Special and zero bypass cases take 1 edge.
- Rounding: truncation toward zero throughout; no guard or sticky bits.

Decomposition:
- Package fp_pkg:
  - fp32_t struct {sign, exp[7:0], frac[22:0]}.
  - Constants FP_BIAS=127, FP_QNAN=32'h7FC00000, FP_POS_INF=32'h7F800000, EXP_MAX=8'hFF.
  - State enum fsub_state_t.
- Sub-module fp_classify: combinational; flags zero/inf/nan per operand. Reusable by the adder and multiplier.

Test Plan:
- 0x40400000 - 0x3F800000 (3-1) -> result 0x40000000, flags 0, out_valid exactly 3 edges after accept.
- 0x3F800000 - 0x40400000 (1-3) -> 0xC0000000; 0x3F800000 - 0xBF800000 (1-(-1)) -> 0x40000000 via carry NORM.
- 0x3F800000 - 0x3F800000 -> 0x00000000, underflow=0. 0x3F800000 - 0x3F7FFFFF -> 0x34000000, latency 26, confirming truncation and 23 left shifts.
- 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000, overflow=1. 0x7F800000 - 0x7F800000 -> 0x7FC00000, latency 1.
- Hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready=0; in_valid pulses are ignored.
- Assert nRST during ALIGN (0x4B000000 - 0x3F800000) -> all outputs return to reset values immediately. Next operation 3-1 -> 0x40000000.
